// File: rtl/neokeon_last_roundfun.sv
// Noekeon final-round output transform: constant-1 injection, Theta with the
// working key, constant-2 injection, registered with a one-cycle latency.
module neokeon_last_roundfun (
    input  logic         inClk,
    input  logic         inRstn,
    input  logic         inValid,
    input  logic [127:0] inDataKey,
    input  logic [127:0] inDataState,
    input  logic [31:0]  constant1,
    input  logic [31:0]  constant2,
    output logic [127:0] outDataState,
    output logic         outValid
);

    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  t0, t1;
    logic [31:0]  b0, b1, b2, b3;
    logic [31:0]  m0, m1, m2, m3;
    logic [127:0] result;

    always_comb begin
        {k0, k1, k2, k3} = inDataKey;
        {a0, a1, a2, a3} = inDataState;

        a0 = a0 ^ constant1;

        // first Theta half mixes the even words into the odd ones
        t0 = a0 ^ a2;
        t0 = t0 ^ {t0[23:0], t0[31:24]} ^ {t0[7:0], t0[31:8]};
        b0 = a0;
        b1 = a1 ^ t0;
        b2 = a2;
        b3 = a3 ^ t0;

        m0 = b0 ^ k0;
        m1 = b1 ^ k1;
        m2 = b2 ^ k2;
        m3 = b3 ^ k3;

        // second Theta half mixes the keyed odd words back into the even ones
        t1 = m1 ^ m3;
        t1 = t1 ^ {t1[23:0], t1[31:24]} ^ {t1[7:0], t1[31:8]};
        m0 = m0 ^ t1 ^ constant2;
        m2 = m2 ^ t1;

        result = {m0, m1, m2, m3};
    end

    always_ff @(posedge inClk) begin
        if (!inRstn) begin
            outDataState <= '0;
            outValid     <= 1'b0;
        end else begin
            outValid <= inValid;
            if (inValid) begin
                outDataState <= result;
            end
        end
    end

endmodule

// File: tb/tb_neokeon_last_roundfun.sv
// Self-checking bench for neokeon_last_roundfun: directed vectors, random
// stream against a word-level reference model, involution and valid-gap checks.
module tb_neokeon_last_roundfun;

    logic         clk = 1'b0;
    logic         rstn;
    logic         valid;
    logic [127:0] key;
    logic [127:0] state;
    logic [31:0]  c1;
    logic [31:0]  c2;
    logic [127:0] out_state;
    logic         out_valid;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [127:0] exp_state;
    logic         exp_valid;

    always #5 clk = ~clk;

    neokeon_last_roundfun dut (
        .inClk        (clk),
        .inRstn       (rstn),
        .inValid      (valid),
        .inDataKey    (key),
        .inDataState  (state),
        .constant1    (c1),
        .constant2    (c2),
        .outDataState (out_state),
        .outValid     (out_valid)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] x);
        return x ^ rotl(x, 8) ^ rotl(x, 24);
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] k, input logic [127:0] s,
                                               input logic [31:0] k1c, input logic [31:0] k2c);
        logic [31:0] a [4];
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i] = s[127 - 32*i -: 32];
            w[i] = k[127 - 32*i -: 32];
        end
        a[0] ^= k1c;
        t = mix(a[0] ^ a[2]);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= w[i];
        t = mix(a[1] ^ a[3]);
        a[0] ^= t;
        a[2] ^= t;
        a[0] ^= k2c;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // advance one clock, update the expected register contents, compare
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rstn) begin
            exp_state = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = valid;
            if (valid) exp_state = ref_model(key, state, c1, c2);
        end
        #1;
        check({tag, "_valid"}, {127'b0, out_valid}, {127'b0, exp_valid});
        check({tag, "_state"}, out_state, exp_state);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] orig;
    logic [127:0] once;

    initial begin
        exp_state = '0;
        exp_valid = 1'b0;

        // reset held with valid, nonzero inputs
        rstn = 1'b0; valid = 1'b1;
        key = rand128(); state = rand128(); c1 = 32'h80; c2 = 32'h1b;
        cycle("reset0");
        cycle("reset1");
        check("reset_state_zero", out_state, 128'h0);

        rstn = 1'b1;
        key = '0; state = '0; c1 = 32'h00000080; c2 = '0;
        cycle("const1");
        check("const1_golden", out_state, 128'h00000080_80008080_00000000_80008080);

        key = 128'h00000000_00000001_00000000_00000000; c1 = '0;
        cycle("key");
        check("key_golden", out_state, 128'h01000101_00000001_01000101_00000000);

        key = '0; c2 = 32'h0000001B;
        cycle("const2");
        check("const2_golden", out_state, 128'h0000001B_00000000_00000000_00000000);

        // random back-to-back stream, starting from a fixed encryption vector
        key = 128'hb1656851699e29fa24b70148503d2dfc;
        state = 128'h0f9b172be357b0bed2fe81e292d599c8;
        c1 = 32'h80; c2 = '0;
        cycle("stream_fixed");
        for (int i = 0; i < 999; i++) begin
            key = rand128(); state = rand128();
            case ($urandom_range(0, 2))
                0: begin c1 = $urandom_range(0, 255); c2 = '0; end
                1: begin c1 = '0; c2 = $urandom_range(0, 255); end
                default: begin c1 = $urandom; c2 = $urandom; end
            endcase
            cycle("stream");
        end

        // involution with zero key and constants
        key = '0; c1 = '0; c2 = '0;
        for (int i = 0; i < 8; i++) begin
            orig = rand128();
            state = orig;
            cycle("inv_a");
            once = out_state;
            state = once;
            cycle("inv_b");
            check("involution", out_state, orig);
        end

        // alternating valid; state must hold during gaps
        for (int i = 0; i < 6; i++) begin
            valid = (i % 2 == 0);
            key = rand128(); state = rand128(); c1 = $urandom; c2 = $urandom;
            cycle("gap");
        end

        // input changes between edges must not disturb the output
        valid = 1'b1; key = rand128(); state = rand128();
        cycle("midcycle_pre");
        orig = out_state;
        #2 state = rand128(); key = rand128();
        #1 check("midcycle_hold", out_state, orig);

        // reset asserted mid-stream discards the in-flight result
        rstn = 1'b0;
        cycle("mid_reset");
        rstn = 1'b1; valid = 1'b1; state = rand128();
        cycle("post_reset");
        valid = 1'b0;
        cycle("post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
